// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready on both sides. Words are
// serialised MSB- or LSB-first, and the last bit of each word is flagged.
module piso_stream #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] PI,
    input  logic             PI_VALID,
    output logic             PI_READY,
    input  logic             SI,
    output logic             O,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             O_LAST
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_shifted;
    logic             load;

    assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], SI} : {SI, sr_q[WIDTH-1:1]};

    // Ready on the last-bit beat lets the next word follow with no bubble.
    assign PI_READY = (state_q == IDLE) ||
                      ((state_q == SHIFT) && (cnt_q == '0) && O_READY);
    assign load     = PI_VALID && PI_READY;

    assign O       = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign O_VALID = (state_q == SHIFT);
    assign O_LAST  = O_VALID && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (load) begin
            sr_d    = PI;
            cnt_d   = CW'(WIDTH - 1);
            state_d = SHIFT;
        end else if ((state_q == SHIFT) && O_READY) begin
            sr_d = sr_shifted;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: an LSB-first and an MSB-first instance share stimulus;
// a bit-queue model checks every cycle and literal streams pin the model.
module tb_piso_stream;

    localparam int unsigned W = 10;

    logic         CLK;
    logic         RESET;
    logic [W-1:0] PI;
    logic         PI_VALID;
    logic         SI;
    logic         O_READY;
    logic [1:0]   pi_ready_w, o_w, o_valid_w, o_last_w;

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          run_chk = 1'b0;

    // Index 0: LSB-first instance, index 1: MSB-first instance.
    bit mq[2][$];
    bit cap[2][$];

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(CLK), .RESET(RESET), .PI(PI), .PI_VALID(PI_VALID),
        .PI_READY(pi_ready_w[0]), .SI(SI), .O(o_w[0]), .O_VALID(o_valid_w[0]),
        .O_READY(O_READY), .O_LAST(o_last_w[0])
    );

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CLK(CLK), .RESET(RESET), .PI(PI), .PI_VALID(PI_VALID),
        .PI_READY(pi_ready_w[1]), .SI(SI), .O(o_w[1]), .O_VALID(o_valid_w[1]),
        .O_READY(O_READY), .O_LAST(o_last_w[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int unsigned d);
        logic [31:0] v = '0;
        foreach (cap[d][i]) v = (v << 1) | 32'(cap[d][i]);
        return v;
    endfunction

    // Model: the queue holds the bits of the current word still to be sent.
    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (RESET) begin
                mq[d].delete();
            end else begin
                bit acc;
                acc = PI_VALID && ((mq[d].size() == 0) || (mq[d].size() == 1 && O_READY));
                if (mq[d].size() > 0 && O_READY) void'(mq[d].pop_front());
                if (acc) begin
                    for (int i = 0; i < int'(W); i++)
                        mq[d].push_back(d == 1 ? PI[int'(W) - 1 - i] : PI[i]);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (run_chk) begin
            for (int d = 0; d < 2; d++) begin
                int unsigned n;
                n = mq[d].size();
                chk($sformatf("o_valid[%0d]", d), 32'(o_valid_w[d]), 32'(n > 0));
                chk($sformatf("o_last[%0d]", d), 32'(o_last_w[d]), 32'(n == 1));
                chk($sformatf("pi_ready[%0d]", d), 32'(pi_ready_w[d]),
                    32'((n == 0) || (n == 1 && O_READY)));
                if (n > 0) chk($sformatf("o[%0d]", d), 32'(o_w[d]), 32'(mq[d][0]));
                if (o_valid_w[d] && O_READY) cap[d].push_back(o_w[d]);
            end
        end
    end

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_cap();
        cap[0].delete();
        cap[1].delete();
    endtask

    task automatic check_stream(input string name, input int unsigned len,
                                input logic [31:0] exp_lsb, input logic [31:0] exp_msb);
        chk({name, "_len_lsb"}, 32'(cap[0].size()), 32'(len));
        chk({name, "_len_msb"}, 32'(cap[1].size()), 32'(len));
        chk({name, "_bits_lsb"}, pack(0), exp_lsb);
        chk({name, "_bits_msb"}, pack(1), exp_msb);
    endtask

    initial begin
        RESET = 1'b1; PI = 10'h3C1; PI_VALID = 1'b1; SI = 1'b1; O_READY = 1'b1;
        step(3);
        run_chk = 1'b1;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk("reset_pi_ready", 32'(pi_ready_w[d]), 32'd1);
            chk("reset_o_valid", 32'(o_valid_w[d]), 32'd0);
            chk("reset_o_last", 32'(o_last_w[d]), 32'd0);
            chk("reset_o", 32'(o_w[d]), 32'd0);
        end
        #1;

        // Single word, O_READY held high.
        clear_cap();
        RESET = 1'b0;
        step(1);
        PI_VALID = 1'b0;
        step(12);
        check_stream("single", 10, 32'h20F, 32'h3C1);

        // Back-pressure after the second accepted bit.
        clear_cap();
        PI_VALID = 1'b1; PI = 10'h3C1;
        step(1);
        PI_VALID = 1'b0;
        step(2);
        O_READY = 1'b0;
        step(1);
        @(negedge CLK);
        chk("hold_o_msb", 32'(o_w[1]), 32'd1);
        chk("hold_valid_msb", 32'(o_valid_w[1]), 32'd1);
        #1;
        step(2);
        O_READY = 1'b1;
        step(12);
        check_stream("bp", 10, 32'h20F, 32'h3C1);

        // Back-to-back words with PI_VALID held.
        clear_cap();
        PI_VALID = 1'b1; PI = 10'h3C1; SI = 1'b0;
        step(1);
        PI = 10'h155;
        step(10);
        PI_VALID = 1'b0;
        step(12);
        check_stream("b2b", 20, {12'h0, 10'b1000001111, 10'b1010101010},
                     {12'h0, 10'h3C1, 10'h155});

        // Reset in the middle of a word, then a clean word.
        PI_VALID = 1'b1; PI = 10'h3C1; SI = 1'b1;
        step(1);
        PI_VALID = 1'b0;
        step(4);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk("midrst_o_valid", 32'(o_valid_w[d]), 32'd0);
            chk("midrst_pi_ready", 32'(pi_ready_w[d]), 32'd1);
        end
        #1;
        clear_cap();
        PI_VALID = 1'b1; PI = 10'h001;
        step(1);
        PI_VALID = 1'b0;
        step(12);
        check_stream("after_rst", 10, 32'h200, 32'h001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
Parametrised parallel-in/serial-out shifter with valid/ready handshakes on both sides. It is the successor to the fixed 10-bit LOAD-driven PISO. It accepts a WIDTH-bit word, serialises it one bit per accepted output beat (MSB- or LSB-first), and flags the last bit of each word. It supports back-to-back words with no bubble and sits between word-oriented datapaths and bit-serial links.

Parameters:
WIDTH, 10, word width in bits; legal range >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
PI  input  WIDTH  parallel word in.
PI_VALID  input  1  PI holds a word to load.
PI_READY  output  1  block can accept a word this cycle.
SI  input  1  serial fill bit, shifted into the vacated end on every shift.
O  output  1  current serial bit.
O_VALID  output  1  O is valid.
O_READY  input  1  downstream accepts O this cycle.
O_LAST  output  1  O is the final bit of the current word.

Behaviour:
- One clock, CLK. RESET is synchronous and active-high.
- State: sr[WIDTH-1:0] shift register; cnt of width clog2(WIDTH) (remaining bits minus 1); FSM with states IDLE and SHIFT.
- Reset (RESET=1 at a rising edge): state=IDLE, sr=0, cnt=0. Resulting outputs: PI_READY=1, O_VALID=0, O_LAST=0, O=0. RESET overrides all handshakes in the same cycle. A word partly shifted when reset arrives is discarded, and no further bits of it appear.
- O = sr[WIDTH-1] if MSB_FIRST else sr[0]. O is driven from the register with no combinational path from PI.
- O_VALID = (state==SHIFT). O_LAST = O_VALID && cnt==0.
- PI_READY = (state==IDLE) || (state==SHIFT && cnt==0 && O_READY). The combinational path O_READY -> PI_READY is intended.
- Load (PI_VALID && PI_READY): sr<=PI, cnt<=WIDTH-1, state<=SHIFT. The first bit of the word is on O the cycle after the load (latency 1).
- Shift (state==SHIFT && O_READY):
  - MSB_FIRST: sr<={sr[WIDTH-2:0],SI}.
  - Otherwise: sr<={SI,sr[WIDTH-1:1]}.
  - If cnt!=0: cnt<=cnt-1.
- Last-bit beat (O_READY with cnt==0):
  - If PI_VALID is also high, the load takes priority over the shift. sr<=PI, cnt<=WIDTH-1, state stays SHIFT. There is no idle bubble, so throughput is WIDTH bits per WIDTH cycles.
  - Otherwise state<=IDLE, and sr takes the shifted value (ignored).
- O_READY low in SHIFT: sr, cnt, state and all outputs hold. O stays stable while O_VALID && !O_READY.
- PI_VALID in SHIFT with cnt!=0: not accepted (PI_READY=0). The upstream holds PI.
- O_READY while IDLE: no effect.
- SI is sampled only on shift beats. SI values never reach O within the same word, because a word is exactly WIDTH beats.

Test Plan:
- Reset then idle, WIDTH=10 -> PI_READY=1, O_VALID=0, O_LAST=0, O=0. Hold RESET with PI_VALID=1 -> nothing loads.
- MSB_FIRST=1: load PI=10'h3C1 with O_READY=1 held -> O over 10 cycles = 1,1,1,1,0,0,0,0,0,1. O_LAST=1 only on the 10th bit. Then O_VALID=0 and PI_READY=1.
- MSB_FIRST=0: same PI=10'h3C1 -> O = 1,0,0,0,0,0,1,1,1,1.
- Back-pressure: load 10'h3C1 (MSB_FIRST=1), drop O_READY for 3 cycles after bit 2 -> O holds 1 with O_VALID=1. The sequence resumes unchanged and totals 10 accepted bits.
- Back-to-back: PI_VALID=1 constant, words 10'h3C1 then 10'h155, O_READY=1 -> PI_READY pulses on the last-bit cycle. The 20 bits stream contiguously (1111000001 then 0101010101), O_VALID never drops, O_LAST fires on bits 10 and 20.
- Reset mid-word: assert RESET after 4 bits of 10'h3C1 -> next cycle O_VALID=0, PI_READY=1. A new load of 10'h001 outputs 0×9 then 1, with no residue.
